// File: rtl/enc_quad_counter_pkg.sv
// Shared definitions for the quadrature encoder front end: record layout and
// quadrature step decoding.
package enc_pkg;

  typedef enum logic [1:0] {
    STEP_NONE = 2'b00,
    STEP_FWD  = 2'b01,
    STEP_ILL  = 2'b10,
    STEP_REV  = 2'b11
  } step_e;

  function automatic int unsigned rec_w(input int unsigned cnt_w, input int unsigned ts_w);
    return 2 + cnt_w + ts_w;
  endfunction

  function automatic int unsigned rec_ovf_bit(input int unsigned cnt_w, input int unsigned ts_w);
    return cnt_w + ts_w + 1;
  endfunction

  function automatic int unsigned rec_zseen_bit(input int unsigned cnt_w, input int unsigned ts_w);
    return cnt_w + ts_w;
  endfunction

  // {A,B} sequence 00,10,11,01 is a Gray code with swapped bits; convert to its rank 0..3.
  function automatic logic [1:0] quad_rank(input logic [1:0] ab);
    return {ab[0], ab[0] ^ ab[1]};
  endfunction

  function automatic step_e quad_step(input logic [1:0] prev_ab, input logic [1:0] cur_ab);
    logic [1:0] d;
    d = quad_rank(cur_ab) - quad_rank(prev_ab);
    case (d)
      2'd0:    return STEP_NONE;
      2'd1:    return STEP_FWD;
      2'd3:    return STEP_REV;
      default: return STEP_ILL;
    endcase
  endfunction

endpackage

// File: rtl/enc_quad_counter_sync_fifo.sv
// First-word fall-through FIFO; a push into a full FIFO is accepted when a pop
// happens in the same cycle.
module sync_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr;
  logic [AW:0]  r_rd;
  logic         w_push_ok;
  logic         w_pop_ok;

  assign o_empty   = (r_wr == r_rd);
  assign o_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop_ok);
  assign o_data    = r_mem[r_rd[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wr[AW-1:0]] <= i_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_push_ok) r_wr <= r_wr + (AW+1)'(1);
      if (w_pop_ok)  r_rd <= r_rd + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/enc_quad_counter.sv
// Quadrature encoder front end: input sync/filtering, wrapping position count,
// Z-index capture and timestamped position records on external sync edges.
module enc_quad_counter
  import enc_pkg::*;
#(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned TS_W       = 32,
  parameter int unsigned FILT_LEN   = 4,
  parameter int unsigned Z_CHAT     = 20,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                             f_clk,
  input  logic                             f_rst,
  input  logic                             rot_a,
  input  logic                             rot_b,
  input  logic                             rot_z,
  input  logic                             ex_sync,
  input  logic                             cnt_clr,
  input  logic                             zero_on_z,
  output logic [CNT_W-1:0]                 pos,
  output logic [CNT_W-1:0]                 z_pos,
  output logic [15:0]                      z_cnt,
  output logic [15:0]                      err_cnt,
  output logic [rec_w(CNT_W, TS_W)-1:0]    m_data,
  output logic                             m_valid,
  input  logic                             m_ready
);

  localparam int unsigned REC_W   = rec_w(CNT_W, TS_W);
  localparam logic [3:0]  RUN_MAX = 4'(FILT_LEN - 1);
  localparam logic [7:0]  ZC      = 8'(Z_CHAT);

  logic [3:0]       r_meta;
  logic [3:0]       r_sync;
  logic [1:0]       r_filt;
  logic [3:0]       r_run [2];
  logic [1:0]       r_prev_ab;
  logic [7:0]       r_chat;
  logic             r_z_ok_d;
  logic             r_ex_d;
  logic             r_ovf;
  logic             r_zpend;
  logic [TS_W-1:0]  r_ts;

  logic             w_z_s;
  logic             w_ex_s;
  logic             w_z_ok;
  logic             w_z_ev;
  logic             w_sync_ev;
  step_e            w_step;
  logic [CNT_W-1:0] w_delta;
  logic [CNT_W-1:0] w_pos_step;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_accept;
  logic [REC_W-1:0] w_rec;
  logic [REC_W-1:0] w_head;

  // Synchronized bit order: {ex_sync, z, a, b}, so r_sync[1:0] is {A,B}.
  assign w_z_s     = r_sync[2];
  assign w_ex_s    = r_sync[3];
  assign w_z_ok    = (r_chat >= ZC);
  assign w_z_ev    = w_z_ok && !r_z_ok_d;
  assign w_sync_ev = w_ex_s && !r_ex_d;
  assign w_step    = quad_step(r_prev_ab, r_filt);

  always_comb begin
    w_delta = '0;
    case (w_step)
      STEP_FWD: w_delta = CNT_W'(1);
      STEP_REV: w_delta = '1;
      default:  w_delta = '0;
    endcase
  end

  assign w_pos_step = pos + w_delta;
  assign w_pop      = m_valid && m_ready;
  assign w_accept   = !w_full || w_pop;
  assign w_rec      = {r_ovf, r_zpend | w_z_ev, pos, r_ts};
  assign m_valid    = !w_empty;
  assign m_data     = m_valid ? w_head : '0;

  always_ff @(posedge f_clk or posedge f_rst) begin
    if (f_rst) begin
      r_meta    <= '0;
      r_sync    <= '0;
      r_filt    <= '0;
      for (int unsigned i = 0; i < 2; i++) r_run[i] <= '0;
      r_prev_ab <= '0;
      r_chat    <= '0;
      r_z_ok_d  <= 1'b0;
      r_ex_d    <= 1'b0;
    end else begin
      r_meta    <= {ex_sync, rot_z, rot_a, rot_b};
      r_sync    <= r_meta;
      r_prev_ab <= r_filt;
      r_z_ok_d  <= w_z_ok;
      r_ex_d    <= w_ex_s;
      for (int unsigned i = 0; i < 2; i++) begin
        if (r_sync[i] == r_filt[i]) begin
          r_run[i] <= '0;
        end else if (r_run[i] == RUN_MAX) begin
          r_filt[i] <= r_sync[i];
          r_run[i]  <= '0;
        end else begin
          r_run[i] <= r_run[i] + 4'd1;
        end
      end
      if (!w_z_s)          r_chat <= '0;
      else if (r_chat < ZC) r_chat <= r_chat + 8'd1;
    end
  end

  always_ff @(posedge f_clk or posedge f_rst) begin
    if (f_rst) begin
      pos     <= '0;
      z_pos   <= '0;
      z_cnt   <= '0;
      err_cnt <= '0;
      r_ts    <= '0;
      r_ovf   <= 1'b0;
      r_zpend <= 1'b0;
    end else begin
      r_ts <= r_ts + TS_W'(1);
      if (cnt_clr)                    pos <= '0;
      else if (w_z_ev && zero_on_z)   pos <= '0;
      else                            pos <= w_pos_step;
      if (w_z_ev) z_pos <= w_pos_step;
      if (cnt_clr)     z_cnt <= '0;
      else if (w_z_ev) z_cnt <= z_cnt + 16'd1;
      if (cnt_clr) err_cnt <= '0;
      else if (w_step == STEP_ILL && err_cnt != '1) err_cnt <= err_cnt + 16'd1;
      // A dropped record keeps any Z marker for the next accepted one.
      if (w_sync_ev && w_accept) begin
        r_ovf   <= 1'b0;
        r_zpend <= 1'b0;
      end else begin
        if (w_sync_ev) r_ovf   <= 1'b1;
        if (w_z_ev)    r_zpend <= 1'b1;
      end
    end
  end

  sync_fifo #(
    .W     (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (f_clk),
    .i_rst   (f_rst),
    .i_push  (w_sync_ev),
    .i_data  (w_rec),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

endmodule
